pe_bs_param: RTL and testbench
==============================

PE_BS_PARAM -- requirements
Module: pe_bs_param

Interface
REQ-001 SHALL have parameters: DW 8, signed sample width; AW 16, signed accumulator width; LANES 3, delay-line taps/accumulators; NW 3, weight slots; WSW 3, shift-amount width; LW 8, window-length width.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  weight slot write strobe
- cfg_idx  in  clog2(NW)  slot index
- cfg_shift  in  WSW  shift amount
- cfg_dir  in  1  1 = left shift, 0 = arithmetic right shift
- cfg_neg  in  1  negate term
- start  in  1  begin window
- len  in  LW  samples per window, sampled on start
- in_valid  in  1  sample valid
- in_data  in  DW  signed sample
- in_ready  out  1  sample accepted when in_valid & in_ready
- out_valid  out  1  results available
- out_ready  in  1  results consumed when out_valid & out_ready
- y  out  LANES*AW  accumulators, lane i at bits [i*AW +: AW]
- sat  out  LANES  sticky per-lane saturation flags
- busy  out  1  state != IDLE

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state == RUN); out_valid = (state == DONE).
REQ-004 In IDLE, start SHALL latch len, zero the delay line, step index, y and sat, and enter RUN on the next edge; with len == 0 it SHALL enter DONE directly.
REQ-005 start outside IDLE SHALL be ignored.
REQ-006 cfg_we SHALL write {shift, dir, neg} to slot cfg_idx only in IDLE; writes in RUN/DONE or with cfg_idx >= NW SHALL be ignored; slots persist across windows.
REQ-007 On each accepted sample: delay line shifts (lane 0 <= in_data, lane i <= lane i-1), step index k advances modulo NW, and remaining count decrements, all on the same edge.
REQ-008 On the same edge, every lane i SHALL add term(op_i, slot k), where op_i is the value lane i holds after that edge (lane 0 uses in_data).
REQ-009 term SHALL be computed at full precision: sign-extend op, shift left or arithmetic-right (floor) by shift, then negate if neg.
REQ-010 Accumulation SHALL saturate to the signed AW range [-2^(AW-1), 2^(AW-1)-1]; on clamp, sat[i] SHALL set and stay set until the next accepted start or reset.
REQ-011 Acceptance of the len-th sample SHALL move the FSM to DONE on that edge; y then holds final sums (zero added latency).
REQ-012 In DONE, y and sat SHALL remain stable until out_valid & out_ready, then the FSM enters IDLE; y and sat hold their values in IDLE until the next start.
REQ-013 No sample SHALL be accepted in IDLE or DONE regardless of in_valid.

Reset
REQ-014 On rst_n low, at any time including mid-window: state IDLE, y = 0, sat = 0, delay line = 0, step index = 0, all weight slots = {0, 0, 0}; in_ready, out_valid and busy are 0.
REQ-015 Reset deassertion SHALL be synchronised internally; first start is honoured on the second edge after release.

Verification
REQ-016 Reset: assert rst_n low mid-RUN -> y = 0, sat = 0, busy = 0, in_ready = 0 immediately (asynchronous).
REQ-017 Basic window: slots {L1}, {R1}, {L2}; len = 3; samples 4, 8, 12 back-to-back -> y lane0 = 60, lane1 = 34, lane2 = 16; out_valid asserts the cycle after the 3rd acceptance.
REQ-018 Sign handling: slot0 {R1}; len = 1; sample -5 -> lane0 = -3 (0xFFFD). Slot0 {L0, neg}; sample 7 -> lane0 = -7.
REQ-019 Saturation: all slots {L7}; len = 3; samples 127 x3 -> lane0 = 32767 with sat[0] = 1; lane1 = 32512 with sat[1] = 0; lane2 = 16256.
REQ-020 Handshake: in_valid toggling 1/0 during RUN -> only accepted samples count. out_ready low for 5 cycles in DONE -> y stable; start and cfg_we ignored. Then out_ready = 1 -> IDLE next edge.
REQ-021 len = 0 -> DONE on the edge after start, y = 0; len = 5 with NW = 3 -> slot index sequence 0, 1, 2, 0, 1.

Source files
------------

// File: rtl/pe_bs_param.sv
// Bit-serial-style shift/add processing element: a delay line feeds LANES signed
// accumulators, each weighted by a per-step shift/negate slot, with saturation.
module pe_bs_param #(
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 16,
   parameter int unsigned LANES = 3,
   parameter int unsigned NW    = 3,
   parameter int unsigned WSW   = 3,
   parameter int unsigned LW    = 8,
   localparam int unsigned IW   = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_we,
   input  logic [IW-1:0]         cfg_idx,
   input  logic [WSW-1:0]        cfg_shift,
   input  logic                  cfg_dir,
   input  logic                  cfg_neg,
   input  logic                  start,
   input  logic [LW-1:0]         len,
   input  logic                  in_valid,
   input  logic [DW-1:0]         in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*AW-1:0]   y,
   output logic [LANES-1:0]      sat,
   output logic                  busy
);

   // Term width holds the largest left shift plus headroom for negating the most negative value.
   localparam int unsigned TW = DW + (1 << WSW);
   localparam int unsigned SW = ((AW > TW) ? AW : TW) + 1;
   localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
   localparam logic signed [SW-1:0] MAXV    = SW'(ACC_MAX);
   localparam logic signed [SW-1:0] MINV    = SW'(ACC_MIN);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   typedef struct packed {
      logic [WSW-1:0] shift;
      logic           dir;
      logic           neg;
   } slot_t;

   function automatic logic signed [TW-1:0] term_f(input logic signed [DW-1:0] op, input slot_t s);
      logic signed [TW-1:0] ext;
      logic signed [TW-1:0] sh;
      ext = TW'(op);
      if (s.dir) sh = ext <<< s.shift;
      else       sh = ext >>> s.shift;
      if (s.neg) sh = -sh;
      return sh;
   endfunction

   logic rst_sync_q;
   logic rst_int_n;

   state_e                 state_q, state_d;
   logic [LW-1:0]          rem_q, rem_d;
   logic [IW-1:0]          k_q, k_d;
   logic signed [DW-1:0]   dl_q [LANES];
   logic signed [DW-1:0]   dl_d [LANES];
   logic signed [AW-1:0]   acc_q [LANES];
   logic signed [AW-1:0]   acc_d [LANES];
   logic [LANES-1:0]       sat_q, sat_d;
   slot_t                  slot_q [NW];
   slot_t                  slot_d [NW];
   logic                   in_ready_q, out_valid_q, busy_q;

   logic signed [DW-1:0]   op [LANES];
   logic signed [SW-1:0]   sum [LANES];
   logic signed [AW-1:0]   nacc [LANES];
   logic [LANES-1:0]       clamp;

   // Async assert, release one edge later so logic leaves reset cleanly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 1'b0;
      else        rst_sync_q <= 1'b1;
   end
   assign rst_int_n = rst_sync_q;

   // Operands are the post-shift delay line contents; lane 0 sees the incoming sample.
   always_comb begin
      op[0] = in_data;
      for (int i = 1; i < LANES; i++) op[i] = dl_q[i-1];
      for (int i = 0; i < LANES; i++) begin
         sum[i]   = SW'(acc_q[i]) + SW'(term_f(op[i], slot_q[k_q]));
         clamp[i] = (sum[i] > MAXV) || (sum[i] < MINV);
         if (sum[i] > MAXV)      nacc[i] = ACC_MAX;
         else if (sum[i] < MINV) nacc[i] = ACC_MIN;
         else                    nacc[i] = AW'(sum[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      k_d     = k_q;
      dl_d    = dl_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      slot_d  = slot_q;
      case (state_q)
         IDLE: begin
            if (cfg_we && (32'(cfg_idx) < NW))
               slot_d[cfg_idx] = '{shift: cfg_shift, dir: cfg_dir, neg: cfg_neg};
            if (start) begin
               rem_d = len;
               k_d   = '0;
               sat_d = '0;
               for (int i = 0; i < LANES; i++) begin
                  dl_d[i]  = '0;
                  acc_d[i] = '0;
               end
               state_d = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (in_valid) begin
               dl_d  = op;
               acc_d = nacc;
               sat_d = sat_q | clamp;
               k_d   = (32'(k_q) == NW - 1) ? '0 : k_q + IW'(1);
               rem_d = rem_q - LW'(1);
               if (rem_q == LW'(1)) state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         k_q         <= '0;
         sat_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            dl_q[i]  <= '0;
            acc_q[i] <= '0;
         end
         for (int i = 0; i < NW; i++) slot_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         k_q         <= k_d;
         sat_q       <= sat_d;
         in_ready_q  <= (state_d == RUN);
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d != IDLE);
         dl_q        <= dl_d;
         acc_q       <= acc_d;
         slot_q      <= slot_d;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_y
      assign y[g*AW +: AW] = acc_q[g];
   end

   assign sat       = sat_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_pe_bs_param.sv
// Directed bench for pe_bs_param: expected window results are queued at start
// and compared by a monitor whenever a result is handed off.
module tb_pe_bs_param;

   localparam int unsigned DW = 8, AW = 16, LANES = 3, NW = 3, WSW = 3, LW = 8;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  cfg_we = 1'b0;
   logic [1:0]            cfg_idx = '0;
   logic [WSW-1:0]        cfg_shift = '0;
   logic                  cfg_dir = 1'b0;
   logic                  cfg_neg = 1'b0;
   logic                  start = 1'b0;
   logic [LW-1:0]         len = '0;
   logic                  in_valid = 1'b0;
   logic [DW-1:0]         in_data = '0;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [LANES*AW-1:0]   y;
   logic [LANES-1:0]      sat;
   logic                  busy;

   typedef struct {
      logic [47:0] y;
      logic [2:0]  sat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   pe_bs_param #(.DW(DW), .AW(AW), .LANES(LANES), .NW(NW), .WSW(WSW), .LW(LW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_shift(cfg_shift),
      .cfg_dir(cfg_dir), .cfg_neg(cfg_neg), .start(start), .len(len), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .sat(sat), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Result handoff happens on the following rising edge; sample mid-cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got y=%h with nothing expected", y);
         end else begin
            e = sb.pop_front();
            check("result_y", 64'(y), 64'(e.y));
            check("result_sat", 64'(sat), 64'(e.sat));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_slot(input int idx, input int sh, input bit dir, input bit neg);
      cfg_we    = 1'b1;
      cfg_idx   = 2'(idx);
      cfg_shift = 3'(sh);
      cfg_dir   = dir;
      cfg_neg   = neg;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic feed(input logic [7:0] d, input bit gap);
      int b;
      if (gap) begin
         in_valid = 1'b0;
         in_data  = 8'h63;
         tick();
      end
      in_valid = 1'b1;
      in_data  = d;
      b = 0;
      while (!in_ready && b < 10) begin
         tick();
         b++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_window(input int n, input logic [7:0] smp [8], input bit gaps,
                             input logic [47:0] ey, input logic [2:0] es);
      sb.push_back('{y: ey, sat: es});
      start = 1'b1;
      len   = 8'(n);
      tick();
      start = 1'b0;
      for (int i = 0; i < n; i++) feed(smp[i], gaps);
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 20) begin
         tick();
         b++;
      end
      check("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #2;
      check("rst_y", 64'(y), 64'd0);
      check("rst_sat", 64'(sat), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // Basic window: L1, R1, L2 with samples 4, 8, 12.
      cfg_slot(0, 1, 1'b1, 1'b0);
      cfg_slot(1, 1, 1'b0, 1'b0);
      cfg_slot(2, 2, 1'b1, 1'b0);
      run_window(3, '{8'd4, 8'd8, 8'd12, 0, 0, 0, 0, 0}, 1'b0, {16'd16, 16'd34, 16'd60}, 3'b000);
      check("basic_out_valid_next", 64'(out_valid), 64'd1);
      check("basic_in_ready_done", 64'(in_ready), 64'd0);
      drain();

      // Gapped input, then a stalled handoff with start and cfg_we pushed at the DUT.
      out_ready = 1'b0;
      run_window(3, '{8'd4, 8'd8, 8'd12, 0, 0, 0, 0, 0}, 1'b1, {16'd16, 16'd34, 16'd60}, 3'b000);
      start = 1'b1; len = 8'd1;
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_shift = 3'd7; cfg_dir = 1'b1; cfg_neg = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_y", 64'(y), 64'({16'd16, 16'd34, 16'd60}));
         check("stall_out_valid", 64'(out_valid), 64'd1);
      end
      start = 1'b0;
      cfg_we = 1'b0;
      out_ready = 1'b1;
      drain();
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_y_hold", 64'(y), 64'({16'd16, 16'd34, 16'd60}));

      // Slot 0 must still be L1 after the ignored write.
      run_window(1, '{8'd4, 0, 0, 0, 0, 0, 0, 0}, 1'b0, {16'd0, 16'd0, 16'd8}, 3'b000);
      drain();

      // Sign handling.
      cfg_slot(0, 1, 1'b0, 1'b0);
      run_window(1, '{8'hFB, 0, 0, 0, 0, 0, 0, 0}, 1'b0, {16'd0, 16'd0, 16'hFFFD}, 3'b000);
      drain();
      cfg_slot(0, 0, 1'b1, 1'b1);
      run_window(1, '{8'd7, 0, 0, 0, 0, 0, 0, 0}, 1'b0, {16'd0, 16'd0, 16'hFFF9}, 3'b000);
      drain();

      // Saturation on lane 0 only.
      cfg_slot(0, 7, 1'b1, 1'b0);
      cfg_slot(1, 7, 1'b1, 1'b0);
      cfg_slot(2, 7, 1'b1, 1'b0);
      run_window(3, '{8'd127, 8'd127, 8'd127, 0, 0, 0, 0, 0}, 1'b0,
                 {16'd16256, 16'd32512, 16'd32767}, 3'b001);
      drain();

      // Zero-length window goes straight to DONE and clears y and sat.
      run_window(0, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 48'd0, 3'b000);
      check("len0_out_valid", 64'(out_valid), 64'd1);
      drain();

      // Five samples walk the slots 0,1,2,0,1.
      cfg_slot(0, 0, 1'b1, 1'b0);
      cfg_slot(1, 1, 1'b1, 1'b0);
      cfg_slot(2, 2, 1'b1, 1'b0);
      run_window(5, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 0, 0, 0}, 1'b0,
                 {16'd12, 16'd21, 16'd31}, 3'b000);
      drain();

      // Reset in the middle of a saturating window.
      cfg_slot(0, 7, 1'b1, 1'b0);
      cfg_slot(1, 7, 1'b1, 1'b0);
      cfg_slot(2, 7, 1'b1, 1'b0);
      start = 1'b1; len = 8'd5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) feed(8'd127, 1'b0);
      check("midrun_sat_pre", 64'(sat), 64'd1);
      check("midrun_busy_pre", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_y", 64'(y), 64'd0);
      check("async_rst_sat", 64'(sat), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_in_ready", 64'(in_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // Slots were cleared to L0 by reset.
      run_window(1, '{8'd5, 0, 0, 0, 0, 0, 0, 0}, 1'b0, {16'd0, 16'd0, 16'd5}, 3'b000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
